glonass_nav_modulator: RTL
==========================

GLONASS_NAV_MODULATOR -- requirements
Module: glonass_nav_modulator

Interface
REQ-001 SHALL have the following ports, each as name, direction, width and meaning:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- chip_en  in  1  one-cycle strobe per ranging-code chip (511 kHz rate).
- prn_chip  in  1  current ranging-code chip, valid when chip_en=1.
- nav_bit  in  1  navigation data bit from the string source.
- nav_valid  in  1  nav_bit is offered.
- nav_ready  out  1  one-bit prefetch buffer is empty; transfer occurs when nav_valid&nav_ready.
- tx_chip  out  1  modulated chip = prn_chip XOR current symbol.
- tx_valid  out  1  tx_chip strobe.
- string_start  out  1  pulse with the first tx_valid of each 2 s string.
- underrun  out  1  sticky flag, set when a data bit is needed but the buffer is empty.

Function
REQ-002 SHALL keep chip_cnt (9 bit) counting 0..510 on each chip_en, wrapping 510->0; chip_cnt=0 marks a code epoch (1 ms).
REQ-003 SHALL implement the FSM IDLE -> DATA -> TMARK -> DATA.
REQ-004 IDLE SHALL apply symbol 0.
- IDLE->DATA on a chip_en with chip_cnt=0 and the buffer full.
REQ-005 DATA SHALL send 85 bits, each 20 epochs long.
- At the first chip of each bit, the buffer is moved into cur_bit and the buffer is marked empty.
- Symbol = cur_bit XOR meander; meander = 0 in epochs 0..9 of the bit and 1 in epochs 10..19.
REQ-006 After epoch 19 of bit 84, DATA SHALL go to TMARK.
REQ-007 TMARK SHALL send 30 symbols, each 10 epochs long, MSB first, with no meander.
- Pattern: 111110001101110101000010010110.
- After symbol 29, the FSM returns to DATA with bit_cnt=0.
REQ-008 A string SHALL be exactly 2000 epochs long (1700 DATA + 300 TMARK).
REQ-009 tx_chip and tx_valid SHALL be registered with a latency of 1 clk after chip_en.
- tx_valid = chip_en delayed by 1 clk.
- In IDLE, tx_chip = prn_chip.
REQ-010 string_start SHALL pulse together with tx_valid for chip 0 of bit 0 of every DATA entry.
REQ-011 nav_ready SHALL equal "buffer empty" and SHALL be independent of the state.
- A transfer and a buffer load in the same cycle SHALL both take effect: the buffer ends full with the new bit.
REQ-012 If the buffer is empty at a DATA bit boundary, SHALL use cur_bit=0, set underrun, and continue timing without stalling.
REQ-013 Counters SHALL advance only on chip_en.
- chip_en=0 freezes all state except the nav handshake.
REQ-014 Counter widths SHALL be:
- epoch-in-bit: 5 bit
- bit_cnt: 7 bit
- tmark symbol count: 5 bit
- All wrap exactly at their terminal values; no overflow states are reachable.

Reset
REQ-015 reset SHALL force:
- state=IDLE, chip_cnt=0, all sub-counters=0
- buffer empty, cur_bit=0
- tx_chip=0, tx_valid=0, string_start=0, underrun=0
REQ-016 reset SHALL override chip_en and any handshake in the same cycle.
- Reset mid-string abandons the string; no partial-string state persists.
REQ-017 underrun SHALL be cleared only by reset.

Structure
REQ-018 Package glonass_pkg SHALL hold:
- CHIPS_PER_EPOCH=511, EPOCHS_PER_BIT=20, MEANDER_EPOCHS=10
- BITS_PER_STRING=85, TMARK_LEN=30, TMARK_EPOCHS=10
- TMARK_PATTERN
- the FSM state enum
REQ-019 The chip/epoch timing (chip_cnt plus the epoch tick) SHALL be a sub-module glonass_epoch_timer, instantiated once; the FSM, buffer and output register stay in the top.

Verification
REQ-020 Reset, then chip_en every 4 clk with nav_valid=0.
- Required: stays in IDLE; tx_chip equals prn_chip delayed 1 clk; nav_ready=1; underrun=0.
REQ-021 Supply nav_bit=1 and keep the buffer fed with 1s.
- Required: string_start at the first epoch boundary; epochs 0..9 of bit 0 give tx_chip = NOT prn_chip; epochs 10..19 give tx_chip = prn_chip.
REQ-022 Feed 85 bits.
- Required: after 1700 epochs, TMARK begins.
- The first 5 symbols (50 epochs) give inverted prn; the next 3 symbols are non-inverted.
- The next string_start comes exactly 2000*511 chip_en strobes after the previous one.
REQ-023 Withhold nav_valid across the boundary to bit 3.
- Required: underrun=1 from that boundary; bit 3 is sent as 0 with meander; timing is unchanged.
- underrun stays 1 until reset.
REQ-024 Assert reset during TMARK symbol 12.
- Required: the next cycle shows all outputs 0 and state IDLE; a restart gives string_start with bit_cnt=0.
REQ-025 Assert nav_valid in the same cycle as a bit-boundary buffer load.
- Required: the new bit is captured; nav_ready=0 the next cycle; no bit is lost or duplicated over 10 bits.

Source files
------------

// File: rtl/glonass_pkg.sv
// Shared constants, time-mark pattern and FSM encoding for the GLONASS
// navigation-data modulator.
package glonass_pkg;
   localparam int CHIPS_PER_EPOCH = 511;
   localparam int EPOCHS_PER_BIT  = 20;
   localparam int MEANDER_EPOCHS  = 10;
   localparam int BITS_PER_STRING = 85;
   localparam int TMARK_LEN       = 30;
   localparam int TMARK_EPOCHS    = 10;

   // Sent MSB first: symbol k of the time mark is TMARK_PATTERN[TMARK_LEN-1-k].
   localparam logic [TMARK_LEN-1:0] TMARK_PATTERN = 30'b111110001101110101000010010110;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_TMARK = 2'd2
   } nav_state_e;
endpackage

// File: rtl/glonass_nav_modulator_if.sv
// Chip strobe, navigation-bit handshake and modulated output bundle.
interface glonass_nav_if;
   logic chip_en;
   logic prn_chip;
   logic nav_bit;
   logic nav_valid;
   logic nav_ready;
   logic tx_chip;
   logic tx_valid;
   logic string_start;
   logic underrun;

   modport master (
      output chip_en, prn_chip, nav_bit, nav_valid,
      input  nav_ready, tx_chip, tx_valid, string_start, underrun
   );

   modport slave (
      input  chip_en, prn_chip, nav_bit, nav_valid,
      output nav_ready, tx_chip, tx_valid, string_start, underrun
   );
endinterface

// File: rtl/glonass_nav_modulator_timer.sv
// Ranging-code chip counter; epoch_tick marks the first chip of each code epoch.
module glonass_epoch_timer
   import glonass_pkg::*;
#(
   parameter int CHIPS = CHIPS_PER_EPOCH
) (
   input  logic clk,
   input  logic reset,
   input  logic chip_en,
   output logic epoch_tick
);
   localparam logic [8:0] CHIP_LAST = 9'(CHIPS - 1);

   logic [8:0] chip_cnt_q;
   logic [8:0] chip_cnt_d;

   always_comb begin
      chip_cnt_d = chip_cnt_q;
      if (chip_en) begin
         chip_cnt_d = (chip_cnt_q == CHIP_LAST) ? 9'd0 : chip_cnt_q + 9'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) chip_cnt_q <= '0;
      else       chip_cnt_q <= chip_cnt_d;
   end

   assign epoch_tick = chip_en && (chip_cnt_q == 9'd0);
endmodule

// File: rtl/glonass_nav_modulator.sv
// Modulates the ranging code with 2 s navigation strings: 85 meandered data bits
// followed by a 30-symbol time mark. Output registered, one clock after chip_en.
module glonass_nav_modulator
   import glonass_pkg::*;
#(
   parameter int CHIPS = CHIPS_PER_EPOCH
) (
   input  logic         clk,
   input  logic         reset,
   glonass_nav_if.slave nav
);
   localparam logic [4:0] EPB_LAST = 5'(EPOCHS_PER_BIT - 1);
   localparam logic [4:0] MEANDER  = 5'(MEANDER_EPOCHS);
   localparam logic [6:0] BIT_LAST = 7'(BITS_PER_STRING - 1);
   localparam logic [4:0] TM_LAST  = 5'(TMARK_LEN - 1);
   localparam logic [4:0] TME_LAST = 5'(TMARK_EPOCHS - 1);

   nav_state_e state_q, state_d;
   logic [4:0] epoch_q, epoch_d;
   logic [6:0] bit_cnt_q, bit_cnt_d;
   logic [4:0] sym_cnt_q, sym_cnt_d;
   logic       cur_bit_q, cur_bit_d;
   logic       buf_bit_q, buf_bit_d;
   logic       buf_full_q, buf_full_d;
   logic       underrun_q, underrun_d;
   logic       tx_chip_q, tx_chip_d;
   logic       tx_valid_q, tx_valid_d;
   logic       string_start_q, string_start_d;
   logic       epoch_tick, load, start, xfer, symbol;

   glonass_epoch_timer #(.CHIPS(CHIPS)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .chip_en    (nav.chip_en),
      .epoch_tick (epoch_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         epoch_q        <= '0;
         bit_cnt_q      <= '0;
         sym_cnt_q      <= '0;
         cur_bit_q      <= 1'b0;
         buf_bit_q      <= 1'b0;
         buf_full_q     <= 1'b0;
         underrun_q     <= 1'b0;
         tx_chip_q      <= 1'b0;
         tx_valid_q     <= 1'b0;
         string_start_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         epoch_q        <= epoch_d;
         bit_cnt_q      <= bit_cnt_d;
         sym_cnt_q      <= sym_cnt_d;
         cur_bit_q      <= cur_bit_d;
         buf_bit_q      <= buf_bit_d;
         buf_full_q     <= buf_full_d;
         underrun_q     <= underrun_d;
         tx_chip_q      <= tx_chip_d;
         tx_valid_q     <= tx_valid_d;
         string_start_q <= string_start_d;
      end
   end

   // Counters hold the position of the epoch currently on air; they only move at epoch starts.
   always_comb begin
      state_d   = state_q;
      epoch_d   = epoch_q;
      bit_cnt_d = bit_cnt_q;
      sym_cnt_d = sym_cnt_q;
      load      = 1'b0;
      start     = 1'b0;
      if (epoch_tick) begin
         unique case (state_q)
            ST_IDLE: begin
               if (buf_full_q) begin
                  state_d   = ST_DATA;
                  epoch_d   = '0;
                  bit_cnt_d = '0;
                  load      = 1'b1;
                  start     = 1'b1;
               end
            end
            ST_DATA: begin
               if (epoch_q == EPB_LAST) begin
                  epoch_d = '0;
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d   = ST_TMARK;
                     bit_cnt_d = '0;
                     sym_cnt_d = '0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 7'd1;
                     load      = 1'b1;
                  end
               end else begin
                  epoch_d = epoch_q + 5'd1;
               end
            end
            ST_TMARK: begin
               if (epoch_q == TME_LAST) begin
                  epoch_d = '0;
                  if (sym_cnt_q == TM_LAST) begin
                     state_d   = ST_DATA;
                     bit_cnt_d = '0;
                     sym_cnt_d = '0;
                     load      = 1'b1;
                     start     = 1'b1;
                  end else begin
                     sym_cnt_d = sym_cnt_q + 5'd1;
                  end
               end else begin
                  epoch_d = epoch_q + 5'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // An empty buffer at a bit boundary sends 0 and latches underrun; a same-cycle transfer still refills it.
   always_comb begin
      xfer       = nav.nav_valid && !buf_full_q;
      cur_bit_d  = cur_bit_q;
      underrun_d = underrun_q;
      if (load) begin
         cur_bit_d  = buf_full_q & buf_bit_q;
         underrun_d = underrun_q | !buf_full_q;
      end
      buf_full_d = xfer | (buf_full_q & !load);
      buf_bit_d  = xfer ? nav.nav_bit : buf_bit_q;

      symbol = 1'b0;
      unique case (state_d)
         ST_DATA:  symbol = cur_bit_d ^ (epoch_d >= MEANDER);
         ST_TMARK: symbol = TMARK_PATTERN[TM_LAST - sym_cnt_d];
         default:  symbol = 1'b0;
      endcase

      tx_valid_d     = nav.chip_en;
      tx_chip_d      = nav.chip_en ? (nav.prn_chip ^ symbol) : tx_chip_q;
      string_start_d = start;
   end

   assign nav.nav_ready    = !buf_full_q;
   assign nav.tx_chip      = tx_chip_q;
   assign nav.tx_valid     = tx_valid_q;
   assign nav.string_start = string_start_q;
   assign nav.underrun     = underrun_q;
endmodule
